// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU control path: opcodes, FSM states,
// datapath select values and the bundled control-strobe record.
package cpu_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_TRAP     = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_SLT   = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        PC_SRC_ALU    = 2'd0,
        PC_SRC_ALUOUT = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_t;

    typedef enum logic [1:0] {
        SRC_B_REG     = 2'd0,
        SRC_B_FOUR    = 2'd1,
        SRC_B_IMM     = 2'd2,
        SRC_B_IMM_SH2 = 2'd3
    } alu_src_b_t;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        pc_src_t    pc_src;
        logic       alu_src_a;
        alu_src_b_t alu_src_b;
        alu_op_t    alu_op;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    function automatic logic is_branch(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/mc_dispatch.sv
// Opcode-to-next-state map evaluated while the controller sits in DECODE.
// Unknown opcodes raise o_illegal and go to TRAP or back to FETCH.
module mc_dispatch
    import cpu_ctrl_pkg::*;
#(
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic [5:0] i_opcode,
    output logic [3:0] o_next_state,
    output logic       o_illegal
);

    state_t w_next;

    always_comb begin
        w_next    = ST_FETCH;
        o_illegal = 1'b0;
        case (i_opcode)
            OP_RTYPE:       w_next = ST_EXEC_R;
            OP_ADDI,
            OP_SLTI:        w_next = ST_EXEC_I;
            OP_LW,
            OP_SW:          w_next = ST_MEM_ADDR;
            OP_BEQ,
            OP_BNE:         w_next = ST_BRANCH;
            OP_J:           w_next = ST_JUMP;
            default: begin
                o_illegal = 1'b1;
                w_next    = (TRAP_ON_ILLEGAL != 0) ? ST_TRAP : ST_FETCH;
            end
        endcase
    end

    assign o_next_state = w_next;

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Main control FSM of the multi-cycle CPU: sequences fetch/decode/execute/
// memory/write-back and drives the datapath strobes and memory handshake.
module multi_cycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W           = 32,
    parameter int TRAP_ON_ILLEGAL = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [5:0]       opcode_i,
    input  logic             zero_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             iord_o,
    output logic             ir_write_o,
    output logic             pc_write_o,
    output logic [1:0]       pc_src_o,
    output logic             alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [1:0]       alu_op_o,
    output logic             reg_write_o,
    output logic             reg_dst_o,
    output logic             mem_to_reg_o,
    output logic             illegal_o,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instr_count_o
);

    state_t           r_state;
    logic             r_illegal;
    logic [CNT_W-1:0] r_instr_count;

    state_t     w_state_next;
    logic [3:0] w_dispatch_state;
    logic       w_dispatch_illegal;
    logic       w_retire;
    logic       w_enter_trap;
    ctrl_t      w_ctrl;
    ctrl_t      w_ctrl_gated;

    mc_dispatch #(
        .TRAP_ON_ILLEGAL (TRAP_ON_ILLEGAL)
    ) u_dispatch (
        .i_opcode     (opcode_i),
        .o_next_state (w_dispatch_state),
        .o_illegal    (w_dispatch_illegal)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FETCH:    if (mem_ready_i) w_state_next = ST_DECODE;
            ST_DECODE:   w_state_next = state_t'(w_dispatch_state);
            ST_EXEC_R:   w_state_next = ST_WB_R;
            ST_WB_R:     w_state_next = ST_FETCH;
            ST_EXEC_I:   w_state_next = ST_WB_I;
            ST_WB_I:     w_state_next = ST_FETCH;
            ST_MEM_ADDR: w_state_next = (opcode_i == OP_SW) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD:   if (mem_ready_i) w_state_next = ST_WB_MEM;
            ST_WB_MEM:   w_state_next = ST_FETCH;
            ST_MEM_WR:   if (mem_ready_i) w_state_next = ST_FETCH;
            ST_BRANCH:   w_state_next = ST_FETCH;
            ST_JUMP:     w_state_next = ST_FETCH;
            ST_TRAP:     w_state_next = ST_TRAP;
            default:     w_state_next = ST_FETCH;
        endcase
    end

    // An instruction retires on any return to FETCH, including a NOP'd illegal opcode.
    assign w_retire     = (w_state_next == ST_FETCH) && (r_state != ST_FETCH);
    assign w_enter_trap = (r_state == ST_DECODE) && w_dispatch_illegal
                          && (TRAP_ON_ILLEGAL != 0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state       <= ST_FETCH;
            r_illegal     <= 1'b0;
            r_instr_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_enter_trap) begin
                r_illegal <= 1'b1;
            end
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_ctrl = CTRL_IDLE;
        case (r_state)
            ST_FETCH: begin
                w_ctrl.mem_req   = 1'b1;
                w_ctrl.alu_src_b = SRC_B_FOUR;
                w_ctrl.alu_op    = ALU_ADD;
                if (mem_ready_i) begin
                    w_ctrl.ir_write = 1'b1;
                    w_ctrl.pc_write = 1'b1;
                    w_ctrl.pc_src   = PC_SRC_ALU;
                end
            end
            ST_DECODE: begin
                w_ctrl.alu_src_b = SRC_B_IMM_SH2;
                w_ctrl.alu_op    = ALU_ADD;
            end
            ST_EXEC_R: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRC_B_REG;
                w_ctrl.alu_op    = ALU_FUNCT;
            end
            ST_WB_R: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.reg_dst   = 1'b1;
            end
            ST_EXEC_I: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            ST_WB_I: begin
                w_ctrl.reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRC_B_IMM;
                w_ctrl.alu_op    = ALU_ADD;
            end
            ST_MEM_RD: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            ST_WB_MEM: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                w_ctrl.mem_req = 1'b1;
                w_ctrl.mem_we  = 1'b1;
                w_ctrl.iord    = 1'b1;
            end
            ST_BRANCH: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRC_B_REG;
                w_ctrl.alu_op    = ALU_SUB;
                w_ctrl.pc_src    = PC_SRC_ALUOUT;
                w_ctrl.pc_write  = is_branch(opcode_i)
                                   && (((opcode_i == OP_BEQ) && zero_i)
                                    || ((opcode_i == OP_BNE) && !zero_i));
            end
            ST_JUMP: begin
                w_ctrl.pc_src   = PC_SRC_JUMP;
                w_ctrl.pc_write = 1'b1;
            end
            default: w_ctrl = CTRL_IDLE;
        endcase
    end

    // Strobes must be dead for the whole reset pulse, not just after the next edge.
    assign w_ctrl_gated = rst_i ? w_ctrl : CTRL_IDLE;

    assign mem_req_o     = w_ctrl_gated.mem_req;
    assign mem_we_o      = w_ctrl_gated.mem_we;
    assign iord_o        = w_ctrl_gated.iord;
    assign ir_write_o    = w_ctrl_gated.ir_write;
    assign pc_write_o    = w_ctrl_gated.pc_write;
    assign pc_src_o      = w_ctrl_gated.pc_src;
    assign alu_src_a_o   = w_ctrl_gated.alu_src_a;
    assign alu_src_b_o   = w_ctrl_gated.alu_src_b;
    assign alu_op_o      = w_ctrl_gated.alu_op;
    assign reg_write_o   = w_ctrl_gated.reg_write;
    assign reg_dst_o     = w_ctrl_gated.reg_dst;
    assign mem_to_reg_o  = w_ctrl_gated.mem_to_reg;
    assign illegal_o     = r_illegal;
    assign state_o       = r_state;
    assign instr_count_o = r_instr_count;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed scoreboard bench for multi_cycle_ctrl: u0 traps on illegal opcodes,
// u1 treats them as NOPs and uses a 2-bit counter so wrap-around is visible.
module tb_multi_cycle_ctrl;

    localparam logic [3:0] S_FETCH = 4'd0,  S_DECODE = 4'd1,  S_EXEC_R = 4'd2,
                           S_WB_R  = 4'd3,  S_EXEC_I = 4'd4,  S_WB_I   = 4'd5,
                           S_MADDR = 4'd6,  S_MEM_RD = 4'd7,  S_WB_MEM = 4'd8,
                           S_MEM_WR = 4'd9, S_BRANCH = 4'd10, S_JUMP   = 4'd11,
                           S_TRAP  = 4'd12;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;

    logic        mem_req, mem_we, iord, ir_write, pc_write, alu_src_a;
    logic        reg_write, reg_dst, mem_to_reg, illegal;
    logic [1:0]  pc_src, alu_src_b, alu_op;
    logic [3:0]  state;
    logic [31:0] count;

    logic        u1_mem_req, u1_mem_we, u1_iord, u1_ir_write, u1_pc_write, u1_alu_src_a;
    logic        u1_reg_write, u1_reg_dst, u1_mem_to_reg, u1_illegal;
    logic [1:0]  u1_pc_src, u1_alu_src_b, u1_alu_op;
    logic [3:0]  u1_state;
    logic [1:0]  u1_count;

    multi_cycle_ctrl #(.CNT_W(32), .TRAP_ON_ILLEGAL(1)) u0 (
        .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode), .zero_i(zero),
        .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
        .iord_o(iord), .ir_write_o(ir_write), .pc_write_o(pc_write),
        .pc_src_o(pc_src), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .alu_op_o(alu_op), .reg_write_o(reg_write), .reg_dst_o(reg_dst),
        .mem_to_reg_o(mem_to_reg), .illegal_o(illegal), .state_o(state),
        .instr_count_o(count)
    );

    multi_cycle_ctrl #(.CNT_W(2), .TRAP_ON_ILLEGAL(0)) u1 (
        .clk_i(clk), .rst_i(rst_n), .opcode_i(opcode), .zero_i(zero),
        .mem_ready_i(mem_ready), .mem_req_o(u1_mem_req), .mem_we_o(u1_mem_we),
        .iord_o(u1_iord), .ir_write_o(u1_ir_write), .pc_write_o(u1_pc_write),
        .pc_src_o(u1_pc_src), .alu_src_a_o(u1_alu_src_a), .alu_src_b_o(u1_alu_src_b),
        .alu_op_o(u1_alu_op), .reg_write_o(u1_reg_write), .reg_dst_o(u1_reg_dst),
        .mem_to_reg_o(u1_mem_to_reg), .illegal_o(u1_illegal), .state_o(u1_state),
        .instr_count_o(u1_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [5:0]  op;
        logic        rdy;
        logic        zero;
        logic [3:0]  st;
        logic [14:0] ctrl;
        logic        ill;
        int          cnt;
        logic [3:0]  st1;
        int          cnt1;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_cnt = 0;
    int   exp_cnt1 = 0;
    logic exp_ill = 1'b0;

    logic [14:0] C_ZERO, C_FETCH_RDY, C_FETCH_WAIT, C_DECODE, C_EXEC_R, C_WB_R;
    logic [14:0] C_EXEC_ADD, C_EXEC_SLT, C_WB_I, C_MEM_RD, C_WB_MEM, C_MEM_WR;
    logic [14:0] C_BR_TAKEN, C_BR_NOT, C_JUMP;

    function automatic logic [14:0] mk(input logic req, input logic we, input logic io,
                                       input logic irw, input logic pcw, input logic [1:0] psrc,
                                       input logic sa, input logic [1:0] sb, input logic [1:0] aop,
                                       input logic rw, input logic rd, input logic m2r);
        return {req, we, io, irw, pcw, psrc, sa, sb, aop, rw, rd, m2r};
    endfunction

    function automatic logic [14:0] obs_ctrl();
        return {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg};
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s @%0t: observed=%h expected=%h", name, $time, obs, expv);
        end
    endtask

    task automatic push2(input logic [5:0] op, input logic rdy, input logic z,
                         input logic [3:0] st, input logic [14:0] c, input logic [3:0] st1);
        exp_t e;
        e.op = op; e.rdy = rdy; e.zero = z; e.st = st; e.ctrl = c;
        e.ill = exp_ill; e.cnt = exp_cnt; e.st1 = st1; e.cnt1 = exp_cnt1;
        sb_q.push_back(e);
    endtask

    task automatic push(input logic [5:0] op, input logic rdy, input logic z,
                        input logic [3:0] st, input logic [14:0] c);
        push2(op, rdy, z, st, c, st);
    endtask

    task automatic retire();
        exp_cnt++;
        exp_cnt1 = (exp_cnt1 + 1) % 4;
    endtask

    task automatic run_q(input string tag);
        exp_t e;
        int   n;
        n = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            opcode = e.op; mem_ready = e.rdy; zero = e.zero;
            #1;
            chk({tag, ".state"}, {28'd0, state}, {28'd0, e.st});
            chk({tag, ".ctrl"}, {17'd0, obs_ctrl()}, {17'd0, e.ctrl});
            chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
            chk({tag, ".count"}, count, e.cnt);
            chk({tag, ".u1_state"}, {28'd0, u1_state}, {28'd0, e.st1});
            chk({tag, ".u1_count"}, {30'd0, u1_count}, e.cnt1);
            @(posedge clk);
            #2;
            n++;
        end
        $display("[tb] %s: %0d cycles checked, count=%0d", tag, n, count);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".state"}, {28'd0, state}, {28'd0, S_FETCH});
        chk({tag, ".ctrl"}, {17'd0, obs_ctrl()}, {17'd0, C_ZERO});
        chk({tag, ".illegal"}, {31'd0, illegal}, 32'd0);
        chk({tag, ".count"}, count, 32'd0);
        chk({tag, ".u1_count"}, {30'd0, u1_count}, 32'd0);
    endtask

    initial begin
        C_ZERO       = 15'd0;
        C_FETCH_RDY  = mk(1,0,0,1,1,2'd0,0,2'd1,2'd0,0,0,0);
        C_FETCH_WAIT = mk(1,0,0,0,0,2'd0,0,2'd1,2'd0,0,0,0);
        C_DECODE     = mk(0,0,0,0,0,2'd0,0,2'd3,2'd0,0,0,0);
        C_EXEC_R     = mk(0,0,0,0,0,2'd0,1,2'd0,2'd2,0,0,0);
        C_WB_R       = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,1,0);
        C_EXEC_ADD   = mk(0,0,0,0,0,2'd0,1,2'd2,2'd0,0,0,0);
        C_EXEC_SLT   = mk(0,0,0,0,0,2'd0,1,2'd2,2'd3,0,0,0);
        C_WB_I       = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,0);
        C_MEM_RD     = mk(1,0,1,0,0,2'd0,0,2'd0,2'd0,0,0,0);
        C_WB_MEM     = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,0,1);
        C_MEM_WR     = mk(1,1,1,0,0,2'd0,0,2'd0,2'd0,0,0,0);
        C_BR_TAKEN   = mk(0,0,0,0,1,2'd1,1,2'd0,2'd1,0,0,0);
        C_BR_NOT     = mk(0,0,0,0,0,2'd1,1,2'd0,2'd1,0,0,0);
        C_JUMP       = mk(0,0,0,0,1,2'd2,0,2'd0,2'd0,0,0,0);

        rst_n = 1'b0; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        chk_reset("reset");
        rst_n = 1'b1;

        push(6'h00, 1, 0, S_FETCH,  C_FETCH_RDY);
        push(6'h00, 1, 0, S_DECODE, C_DECODE);
        push(6'h00, 1, 0, S_EXEC_R, C_EXEC_R);
        push(6'h00, 1, 0, S_WB_R,   C_WB_R);
        retire();
        run_q("add");

        push(6'h23, 1, 0, S_FETCH,  C_FETCH_RDY);
        push(6'h23, 1, 0, S_DECODE, C_DECODE);
        push(6'h23, 1, 0, S_MADDR,  C_EXEC_ADD);
        push(6'h23, 0, 0, S_MEM_RD, C_MEM_RD);
        push(6'h23, 0, 0, S_MEM_RD, C_MEM_RD);
        push(6'h23, 1, 0, S_MEM_RD, C_MEM_RD);
        push(6'h23, 1, 0, S_WB_MEM, C_WB_MEM);
        retire();
        run_q("lw_wait2");

        push(6'h2B, 1, 0, S_FETCH,  C_FETCH_RDY);
        push(6'h2B, 1, 0, S_DECODE, C_DECODE);
        push(6'h2B, 1, 0, S_MADDR,  C_EXEC_ADD);
        push(6'h2B, 1, 0, S_MEM_WR, C_MEM_WR);
        retire();
        run_q("sw");

        push(6'h08, 1, 0, S_FETCH,  C_FETCH_RDY);
        push(6'h08, 1, 0, S_DECODE, C_DECODE);
        push(6'h08, 1, 0, S_EXEC_I, C_EXEC_ADD);
        push(6'h08, 1, 0, S_WB_I,   C_WB_I);
        retire();
        run_q("addi");

        push(6'h0A, 1, 0, S_FETCH,  C_FETCH_RDY);
        push(6'h0A, 1, 0, S_DECODE, C_DECODE);
        push(6'h0A, 1, 0, S_EXEC_I, C_EXEC_SLT);
        push(6'h0A, 1, 0, S_WB_I,   C_WB_I);
        retire();
        run_q("slti");

        for (int k = 0; k < 4; k++) begin
            logic [5:0] bop;
            logic       bz;
            bop = (k < 2) ? 6'h04 : 6'h05;
            bz  = (k == 0 || k == 3) ? 1'b1 : 1'b0;
            push(bop, 1, bz, S_FETCH,  C_FETCH_RDY);
            push(bop, 1, bz, S_DECODE, C_DECODE);
            push(bop, 1, bz, S_BRANCH, (k == 0 || k == 2) ? C_BR_TAKEN : C_BR_NOT);
            retire();
            run_q($sformatf("branch_op%0h_z%0d", bop, bz));
        end

        push(6'h02, 1, 0, S_FETCH,  C_FETCH_RDY);
        push(6'h02, 1, 0, S_DECODE, C_DECODE);
        push(6'h02, 1, 0, S_JUMP,   C_JUMP);
        retire();
        run_q("j");

        push(6'h02, 0, 0, S_FETCH,  C_FETCH_WAIT);
        push(6'h02, 0, 0, S_FETCH,  C_FETCH_WAIT);
        push(6'h02, 0, 0, S_FETCH,  C_FETCH_WAIT);
        push(6'h02, 1, 0, S_FETCH,  C_FETCH_RDY);
        push(6'h02, 1, 0, S_DECODE, C_DECODE);
        push(6'h02, 1, 0, S_JUMP,   C_JUMP);
        retire();
        run_q("fetch_wait3");

        push(6'h2B, 1, 0, S_FETCH,  C_FETCH_RDY);
        push(6'h2B, 1, 0, S_DECODE, C_DECODE);
        push(6'h2B, 1, 0, S_MADDR,  C_EXEC_ADD);
        push(6'h2B, 0, 0, S_MEM_WR, C_MEM_WR);
        run_q("sw_pre_reset");
        rst_n = 1'b0;
        #1;
        chk_reset("reset_mid_memwr");
        mem_ready = 1'b1;
        @(posedge clk);
        #2;
        chk_reset("reset_held");
        rst_n = 1'b1;
        exp_cnt  = 0;
        exp_cnt1 = 0;

        push2(6'h3F, 1, 0, S_FETCH,  C_FETCH_RDY, S_FETCH);
        push2(6'h3F, 1, 0, S_DECODE, C_DECODE,    S_DECODE);
        exp_ill  = 1'b1;
        exp_cnt1 = 1;
        push2(6'h3F, 1, 0, S_TRAP, C_ZERO, S_FETCH);
        push2(6'h3F, 1, 0, S_TRAP, C_ZERO, S_DECODE);
        exp_cnt1 = 2;
        push2(6'h00, 1, 1, S_TRAP, C_ZERO, S_FETCH);
        run_q("illegal_3f");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
